// File: rtl/pmem_responder_pkg.sv
// Shared types and constants for the physical-memory responder.
package pmem_responder_pkg;

    localparam int unsigned WORD_BITS        = 16;
    localparam int unsigned MEMBAND_BITS     = 128;
    localparam int unsigned PMEM_OFFSET_BITS = 4;
    localparam int unsigned CNT_BITS         = 8;

    typedef logic [WORD_BITS-1:0]    lc3b_word;
    typedef logic [MEMBAND_BITS-1:0] lc3b_memband;

    typedef enum logic [1:0] {
        PMEM_IDLE,
        PMEM_BUSY,
        PMEM_RESP
    } lc3b_pmem_state;

    // Operation captured at acceptance; the line index is latched separately
    // because its width depends on the responder's LINE_BITS.
    typedef struct packed {
        logic        write;
        lc3b_memband wdata;
    } pmem_req_t;

endpackage

// File: rtl/pmem_responder_if.sv
// Cache-to-memory line bus; master is the cache, slave is the responder.
interface pmem_responder_if;
    import pmem_responder_pkg::*;

    logic        pmem_read;
    logic        pmem_write;
    lc3b_word    pmem_address;
    lc3b_memband pmem_wdata;
    lc3b_memband pmem_rdata;
    logic        pmem_resp;
    logic        protocol_err;

    modport master (
        output pmem_read,
        output pmem_write,
        output pmem_address,
        output pmem_wdata,
        input  pmem_rdata,
        input  pmem_resp,
        input  protocol_err
    );

    modport slave (
        input  pmem_read,
        input  pmem_write,
        input  pmem_address,
        input  pmem_wdata,
        output pmem_rdata,
        output pmem_resp,
        output protocol_err
    );

endinterface

// File: rtl/pmem_responder_line_store.sv
// Line-organised storage array with a registered, read-enabled output port.
// Contents are deliberately not reset.
module pmem_line_store
    import pmem_responder_pkg::*;
#(
    parameter int unsigned LINE_BITS = 12
) (
    input  logic                 clk,
    input  logic                 write,
    input  logic                 read,
    input  logic [LINE_BITS-1:0] line,
    input  lc3b_memband          datain,
    output lc3b_memband          dataout
);

    localparam int unsigned DEPTH = 1 << LINE_BITS;

    lc3b_memband mem [DEPTH];

    // Synchronous write and registered read of the addressed line.
    always_ff @(posedge clk) begin
        if (write) begin
            mem[line] <= datain;
        end
        if (read) begin
            dataout <= mem[line];
        end
    end

endmodule

// File: rtl/pmem_responder.sv
// Physical-memory responder: accepts one line read/write at a time and
// answers with a single-cycle pmem_resp after a fixed latency.
module pmem_responder
    import pmem_responder_pkg::*;
#(
    parameter int unsigned LATENCY   = 10,
    parameter int unsigned LINE_BITS = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    pmem_responder_if.slave  bus
);

    if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
        $error("pmem_responder: LATENCY must be within 1..255");
    end
    if (LINE_BITS < 1 || LINE_BITS > WORD_BITS - PMEM_OFFSET_BITS) begin : g_bad_line_bits
        $error("pmem_responder: LINE_BITS must be within 1..12");
    end

    localparam int unsigned         LINE_HI     = LINE_BITS + PMEM_OFFSET_BITS - 1;
    localparam logic [CNT_BITS-1:0] CNT_LOAD    = CNT_BITS'(LATENCY - 1);
    localparam logic [CNT_BITS-1:0] CNT_LAST    = CNT_BITS'(1);
    localparam bit                  DIRECT_RESP = (LATENCY == 1);

    lc3b_pmem_state        state;
    logic [CNT_BITS-1:0]   cnt;
    pmem_req_t             req_q;
    logic [LINE_BITS-1:0]  line_q;
    logic                  resp_q;
    logic                  perr_q;
    logic                  rdata_valid_q;
    lc3b_memband           store_dout;

    logic                  accept_c;
    logic                  to_resp_c;
    logic                  op_write_c;
    logic [LINE_BITS-1:0]  line_c;
    lc3b_memband           wdata_c;
    logic                  store_wr_c;
    logic                  store_rd_c;
    logic                  addr_unused;

    // Offset and aliased high address bits are intentionally ignored.
    assign addr_unused = ^bus.pmem_address;

    // In IDLE the live request feeds the store (needed when LATENCY is 1);
    // otherwise the latched copy is used and the live inputs are ignored.
    always_comb begin
        accept_c   = (state == PMEM_IDLE) && (bus.pmem_read || bus.pmem_write);
        to_resp_c  = 1'b0;
        op_write_c = req_q.write;
        line_c     = line_q;
        wdata_c    = req_q.wdata;
        if (state == PMEM_IDLE) begin
            op_write_c = bus.pmem_write;
            line_c     = bus.pmem_address[LINE_HI:PMEM_OFFSET_BITS];
            wdata_c    = bus.pmem_wdata;
            to_resp_c  = accept_c && DIRECT_RESP;
        end else if (state == PMEM_BUSY) begin
            to_resp_c  = (cnt == CNT_LAST);
        end
        // Store side effects only on the edge entering RESP, never under reset.
        store_wr_c = reset_n && to_resp_c && op_write_c;
        store_rd_c = reset_n && to_resp_c && !op_write_c;
    end

    // Control FSM, latency counter, request latch and sticky error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= PMEM_IDLE;
            cnt           <= '0;
            req_q         <= '0;
            line_q        <= '0;
            resp_q        <= 1'b0;
            perr_q        <= 1'b0;
            rdata_valid_q <= 1'b0;
        end else begin
            resp_q <= to_resp_c;
            if (to_resp_c && !op_write_c) begin
                rdata_valid_q <= 1'b1;
            end
            case (state)
                PMEM_IDLE: begin
                    if (accept_c) begin
                        req_q.write <= bus.pmem_write;
                        req_q.wdata <= bus.pmem_wdata;
                        line_q      <= bus.pmem_address[LINE_HI:PMEM_OFFSET_BITS];
                        cnt         <= CNT_LOAD;
                        state       <= DIRECT_RESP ? PMEM_RESP : PMEM_BUSY;
                        if (bus.pmem_read && bus.pmem_write) begin
                            perr_q <= 1'b1;
                        end
                    end
                end
                PMEM_BUSY: begin
                    cnt <= cnt - CNT_LAST;
                    if (to_resp_c) begin
                        state <= PMEM_RESP;
                    end
                end
                PMEM_RESP: begin
                    state <= PMEM_IDLE;
                end
                default: begin
                    state <= PMEM_IDLE;
                end
            endcase
        end
    end

    pmem_line_store #(
        .LINE_BITS (LINE_BITS)
    ) u_store (
        .clk     (clk),
        .write   (store_wr_c),
        .read    (store_rd_c),
        .line    (line_c),
        .datain  (wdata_c),
        .dataout (store_dout)
    );

    // Read data reads as zero until the first read after reset completes.
    assign bus.pmem_resp    = resp_q;
    assign bus.protocol_err = perr_q;
    assign bus.pmem_rdata   = rdata_valid_q ? store_dout : '0;

endmodule
